// File: rtl/snn_pkg.sv
// ============================================================================
// snn_pkg : shared types and helpers for the spiking-neuron layer scheduler
// Revision 1.0
// ============================================================================
`default_nettype none

package snn_pkg;

  localparam int INT_WIDTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ACCUM  = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Unsigned add clamped to the largest value representable in `width` bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          width);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << width) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/snn_weight_mem.sv
// ============================================================================
// snn_weight_mem : per-(neuron, input) weight register file, async read
// Revision 1.0
// ============================================================================
`default_nettype none

module snn_weight_mem
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS  = 2,
  parameter int NUM_NEURONS = 4,
  parameter int INT_WIDTH   = INT_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH  = 3,
  parameter int N_WIDTH     = 2,
  parameter int I_WIDTH     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [INT_WIDTH-1:0]  wdata,
  input  logic [N_WIDTH-1:0]    rd_n,
  input  logic [I_WIDTH-1:0]    rd_i,
  output logic [INT_WIDTH-1:0]  rdata
);

  localparam int C_DEPTH = NUM_NEURONS * NUM_INPUTS;

  logic [INT_WIDTH-1:0]  r_regs [C_DEPTH];
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  assign w_rd_addr = ADDR_WIDTH'(int'(rd_n) * NUM_INPUTS + int'(rd_i));
  assign rdata     = r_regs[w_rd_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < C_DEPTH; k++) begin
        r_regs[k] <= '0;
      end
    end else if (we && (int'(waddr) < C_DEPTH)) begin
      // Out-of-range addresses are silently dropped.
      r_regs[waddr] <= wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/snn_layer_scheduler.sv
// ============================================================================
// snn_layer_scheduler : time-multiplexed integrate-and-fire layer controller
// Revision 1.0
// ============================================================================
`default_nettype none

module snn_layer_scheduler
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS    = 2,
  parameter int NUM_NEURONS   = 4,
  parameter int INT_WIDTH     = INT_WIDTH_DEFAULT,
  parameter int THRESHOLD     = 8,
  localparam int ADDR_WIDTH   = (NUM_NEURONS * NUM_INPUTS > 1) ?
                                $clog2(NUM_NEURONS * NUM_INPUTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step_start,
  input  logic [NUM_INPUTS-1:0]  in_spikes,
  input  logic                   cfg_we,
  input  logic [ADDR_WIDTH-1:0]  cfg_addr,
  input  logic [INT_WIDTH-1:0]   cfg_data,
  output logic                   busy,
  output logic                   step_done,
  output logic [NUM_NEURONS-1:0] out_spikes
);

  localparam int N_WIDTH = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int I_WIDTH = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1;

  localparam logic [N_WIDTH-1:0]   C_N_LAST = N_WIDTH'(NUM_NEURONS - 1);
  localparam logic [I_WIDTH-1:0]   C_I_LAST = I_WIDTH'(NUM_INPUTS - 1);
  localparam logic [INT_WIDTH-1:0] C_THRESH = INT_WIDTH'(THRESHOLD);

  state_t                r_state;
  logic [N_WIDTH-1:0]    r_n;
  logic [I_WIDTH-1:0]    r_i;
  logic [INT_WIDTH-1:0]  r_acc;
  logic [NUM_INPUTS-1:0] r_spikes;
  logic [INT_WIDTH-1:0]  r_mem [NUM_NEURONS];

  logic [INT_WIDTH-1:0]  w_weight;
  logic [INT_WIDTH-1:0]  w_sum;
  logic                  w_cfg_we;

  // Configuration writes are only honoured between timesteps.
  assign w_cfg_we = cfg_we && (r_state == IDLE);
  assign w_sum    = INT_WIDTH'(sat_add(32'(r_acc), 32'(w_weight), INT_WIDTH));

  snn_weight_mem #(
    .NUM_INPUTS  (NUM_INPUTS),
    .NUM_NEURONS (NUM_NEURONS),
    .INT_WIDTH   (INT_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .N_WIDTH     (N_WIDTH),
    .I_WIDTH     (I_WIDTH)
  ) u_weight_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (w_cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .rd_n  (r_n),
    .rd_i  (r_i),
    .rdata (w_weight)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      busy       <= 1'b0;
      step_done  <= 1'b0;
      out_spikes <= '0;
      r_n        <= '0;
      r_i        <= '0;
      r_acc      <= '0;
      r_spikes   <= '0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      step_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (step_start) begin
            r_spikes   <= in_spikes;
            out_spikes <= '0;
            r_n        <= '0;
            busy       <= 1'b1;
            r_state    <= LOAD;
          end
        end
        LOAD: begin
          r_acc   <= r_mem[r_n];
          r_i     <= '0;
          r_state <= ACCUM;
        end
        ACCUM: begin
          if (r_spikes[r_i]) begin
            r_acc <= w_sum;
          end
          if (r_i == C_I_LAST) begin
            r_state <= COMMIT;
          end else begin
            r_i <= r_i + 1'b1;
          end
        end
        COMMIT: begin
          // A firing neuron resets its membrane; otherwise the charge persists.
          if (r_acc >= C_THRESH) begin
            out_spikes[r_n] <= 1'b1;
            r_mem[r_n]      <= '0;
          end else begin
            r_mem[r_n] <= r_acc;
          end
          if (r_n == C_N_LAST) begin
            r_state <= DONE;
          end else begin
            r_n     <= r_n + 1'b1;
            r_state <= LOAD;
          end
        end
        DONE: begin
          step_done <= 1'b1;
          busy      <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
